// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: streams a word-aligned window of the data BRAM over valid/ready; DMEM_DUMP_CHECKSUM_EN adds a running checksum port
module dmem_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last
`ifdef DMEM_DUMP_CHECKSUM_EN
  ,output logic [DATA_WIDTH-1:0] checksum
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0] rem;
  logic accept, hs, last_word;
  assign accept = state == IDLE && start;
  assign hs = state == HOLD && m_valid && m_ready;
  assign last_word = rem == CNT_WIDTH'(1);
  // state register
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_next;
  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = start ? (word_count == '0 ? DONE : FETCH) : IDLE;
      FETCH: state_next = HOLD;
      HOLD:  state_next = hs ? (last_word ? DONE : FETCH) : HOLD;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // combinational outputs: busy spans every non-idle state, BRAM is addressed from the walk pointer
  always_comb begin
    busy = state != IDLE;
    dbg_addr = cur_addr;
  end
  // walk pointer, word counter, output beat register and the registered done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr <= '0;
      rem <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_addr <= '0;
      m_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DONE;
      if (accept) begin
        cur_addr <= base_addr & ~ADDR_WIDTH'(3);
        rem <= word_count;
      end
      if (state == FETCH) begin
        m_data <= dbg_data;
        m_addr <= cur_addr;
        m_valid <= 1'b1;
        m_last <= last_word;
      end
      if (hs) begin
        m_valid <= 1'b0;
        m_last <= 1'b0;
        rem <= rem - CNT_WIDTH'(1);
        if (!last_word) cur_addr <= cur_addr + ADDR_WIDTH'(4);
      end
    end
  end
`ifdef DMEM_DUMP_CHECKSUM_EN
  // running sum of accepted beats, restarted by each accepted start
  always_ff @(posedge clk)
    if (!rst || accept) checksum <= '0;
    else if (hs) checksum <= checksum + m_data;
`endif
endmodule
